// File: rtl/if_fetch_unit_pkg.sv
// ============================================================================
// Module      : if_fetch_unit_pkg
// Description : Shared encodings for the instruction-fetch stage: PC_sel
//               codes (same encoding the main decoder drives), fetch FSM
//               state codes, reset PC default and a branch-offset helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_fetch_unit_pkg;

   localparam logic [31:0] c_RESET_PC = 32'h0000_3000;
   localparam int unsigned c_IMEM_TMO = 16;

   // Next-PC source selected by the decoder
   typedef enum logic [1:0] {
      PC_SEQ = 2'b00,   // pc + 4
      PC_BR  = 2'b01,   // conditional relative branch
      PC_J   = 2'b10,   // j / jal pseudo-direct target
      PC_JR  = 2'b11    // register target
   } pc_sel_e;

   typedef enum logic [1:0] {
      S_RESET = 2'b00,
      S_REQ   = 2'b01,
      S_HOLD  = 2'b10,
      S_HALT  = 2'b11
   } fetch_state_e;

   // Sign-extended 16-bit word offset converted to a byte offset
   function automatic logic [31:0] br_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_unit_if.sv
// ============================================================================
// Module      : if_fetch_unit_if
// Description : Bundle of the fetch stage's instruction-memory handshake and
//               its decode-side interface.
//               master : the fetch unit (drives imem_req/addr, instr, pc ...)
//               slave  : memory + decoder side (drives ready/rdata, accept,
//                        PC_sel, br_taken, rs_data)
// Signals     : imem_req, imem_addr, imem_ready, imem_rdata, instr_valid,
//               instr_accept, instr, opcode, func, pc, pc_plus4, PC_sel,
//               br_taken, rs_data, fetch_err
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_fetch_unit_if;

   // instruction memory
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   // decode side
   logic        instr_valid;
   logic        instr_accept;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [5:0]  func;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [1:0]  PC_sel;
   logic        br_taken;
   logic [31:0] rs_data;
   logic        fetch_err;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, opcode, func,
             pc, pc_plus4, fetch_err,
      input  imem_ready, imem_rdata, instr_accept, PC_sel, br_taken, rs_data
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, opcode, func,
             pc, pc_plus4, fetch_err,
      output imem_ready, imem_rdata, instr_accept, PC_sel, br_taken, rs_data
   );

endinterface

`default_nettype wire

// File: rtl/if_fetch_unit_npc_calc.sv
// ============================================================================
// Module      : if_fetch_unit_npc_calc
// Description : Combinational next-PC multiplexer.
// Ports       : i_pc        current pc
//               i_imm26     instr[25:0] (branch offset uses the low 16 bits)
//               i_pc_sel    next-PC source
//               i_br_taken  branch outcome (PC_BR only)
//               i_rs_data   register target (PC_JR only)
//               o_pc_plus4  pc + 4
//               o_next_pc   selected next pc
//               o_misalign  register target is not word aligned
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_unit_npc_calc
   import if_fetch_unit_pkg::*;
(
   input  wire logic [31:0] i_pc,
   input  wire logic [25:0] i_imm26,
   input  pc_sel_e          i_pc_sel,
   input  wire logic        i_br_taken,
   input  wire logic [31:0] i_rs_data,
   output logic      [31:0] o_pc_plus4,
   output logic      [31:0] o_next_pc,
   output logic             o_misalign
);

   logic [31:0] w_pc_plus4;
   logic [31:0] w_br_target;
   logic [31:0] w_j_target;

   // All arithmetic wraps modulo 2^32; no overflow detection is wanted.
   assign w_pc_plus4  = i_pc + 32'd4;
   assign w_br_target = w_pc_plus4 + br_offset(i_imm26[15:0]);
   assign w_j_target  = {w_pc_plus4[31:28], i_imm26, 2'b00};

   always_comb begin
      o_next_pc  = w_pc_plus4;
      o_misalign = 1'b0;
      case (i_pc_sel)
         PC_SEQ: o_next_pc = w_pc_plus4;
         PC_BR:  o_next_pc = i_br_taken ? w_br_target : w_pc_plus4;
         PC_J:   o_next_pc = w_j_target;
         PC_JR: begin
            o_next_pc  = i_rs_data;
            o_misalign = (i_rs_data[1:0] != 2'b00);
         end
         default: o_next_pc = w_pc_plus4;
      endcase
   end

   assign o_pc_plus4 = w_pc_plus4;

endmodule

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction-fetch stage. Requests the word at pc, latches it
//               into the instruction register, holds it until decode accepts
//               and then moves pc to the next-PC selected by the decoder.
//               A memory timeout or a misaligned register target halts the
//               stage with a sticky fetch_err until reset.
// Ports       : clk  system clock, rising edge
//               rst  synchronous active-high reset
//               bus  if_fetch_unit_if.master (imem handshake + decode side)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = c_RESET_PC,
   parameter int unsigned IMEM_TMO = c_IMEM_TMO
)
(
   input  wire logic        clk,
   input  wire logic        rst,
   if_fetch_unit_if.master  bus
);

   // Counter only needs to reach IMEM_TMO-1; the IMEM_TMO-th wait cycle errors.
   localparam int c_TMO_W = (IMEM_TMO > 1) ? $clog2(IMEM_TMO) : 1;
   localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(IMEM_TMO - 1);

   fetch_state_e        r_state;
   fetch_state_e        w_state_nxt;
   logic [31:0]         r_pc;
   logic [31:0]         r_instr;
   logic                r_err;
   logic [c_TMO_W-1:0]  r_tmo;
   logic [c_TMO_W-1:0]  w_tmo_nxt;

   logic                w_fetch_done;
   logic                w_pc_load;
   logic                w_err_set;

   logic [31:0]         w_pc_plus4;
   logic [31:0]         w_next_pc;
   logic                w_misalign;

   if_fetch_unit_npc_calc u_npc_calc (
      .i_pc       (r_pc),
      .i_imm26    (r_instr[25:0]),
      .i_pc_sel   (pc_sel_e'(bus.PC_sel)),
      .i_br_taken (bus.br_taken),
      .i_rs_data  (bus.rs_data),
      .o_pc_plus4 (w_pc_plus4),
      .o_next_pc  (w_next_pc),
      .o_misalign (w_misalign)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_RESET;
         r_pc    <= RESET_PC;
         r_instr <= '0;
         r_err   <= 1'b0;
         r_tmo   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_tmo   <= w_tmo_nxt;
         if (w_fetch_done) r_instr <= bus.imem_rdata;
         if (w_pc_load)    r_pc    <= w_next_pc;
         if (w_err_set)    r_err   <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_tmo_nxt    = r_tmo;
      w_fetch_done = 1'b0;
      w_pc_load    = 1'b0;
      w_err_set    = 1'b0;
      case (r_state)
         S_RESET: begin
            w_state_nxt = S_REQ;
            w_tmo_nxt   = '0;
         end
         S_REQ: begin
            if (bus.imem_ready) begin
               w_fetch_done = 1'b1;
               w_tmo_nxt    = '0;
               w_state_nxt  = S_HOLD;
            end else if (r_tmo == c_TMO_LAST) begin
               w_err_set   = 1'b1;
               w_state_nxt = S_HALT;
            end else begin
               w_tmo_nxt = r_tmo + 1'b1;
            end
         end
         S_HOLD: begin
            // A misaligned register target halts without moving pc so the
            // faulting jr stays observable.
            if (bus.instr_accept) begin
               if (w_misalign) begin
                  w_err_set   = 1'b1;
                  w_state_nxt = S_HALT;
               end else begin
                  w_pc_load   = 1'b1;
                  w_tmo_nxt   = '0;
                  w_state_nxt = S_REQ;
               end
            end
         end
         S_HALT: begin
            w_state_nxt = S_HALT;
         end
         default: w_state_nxt = S_RESET;
      endcase
   end

   // Valid is exactly "holding a fetched word", so it derives from state.
   assign bus.imem_req    = (r_state == S_REQ);
   assign bus.imem_addr   = r_pc;
   assign bus.instr_valid = (r_state == S_HOLD);
   assign bus.instr       = r_instr;
   assign bus.opcode      = r_instr[31:26];
   assign bus.func        = r_instr[5:0];
   assign bus.pc          = r_pc;
   assign bus.pc_plus4    = w_pc_plus4;
   assign bus.fetch_err   = r_err;

endmodule

`default_nettype wire
